garage_door_supervisor: RTL and testbench
=========================================

// Module: garage_door_supervisor
// PURPOSE
//  Supervisory controller that sequences the garage door FSM (activate/UP_MAX/DN_MAX/UP_M/DN_M).
//  Arbitrates two requesters (wall button, remote) into single activate pulses and auto-closes an open door.
//  Enforces motor-ack, travel-timeout, obstruction and sensor-consistency checks.
//  Sits between user inputs and the door FSM; motor_en gates the FSM's UP_M/DN_M at top level.
// PARAMETERS
//  CNT_W           16    width of the shared cycle counter
//  ACK_CYC         4     cycles allowed from activate pulse to motor output asserting
//  MOVE_TIMEOUT    500   max cycles in OPENING/CLOSING before reaching the limit switch
//  AUTO_CLOSE_CYC  1000  cycles the door stays OPEN before an automatic close
// PORTS
//  clk         in   1  system clock, all logic on rising edge
//  rst         in   1  synchronous reset, active-high
//  wall_btn    in   1  wall button level, already synchronised/debounced
//  remote_btn  in   1  remote receiver level, already synchronised/debounced
//  up_max      in   1  upper limit switch (door fully open)
//  dn_max      in   1  lower limit switch (door fully closed)
//  obstruct    in   1  beam-break sensor, 1 = obstruction present
//  up_m        in   1  door FSM up-motor output
//  dn_m        in   1  door FSM down-motor output
//  activate    out  1  one-cycle pulse to door FSM Activate input
//  motor_en    out  1  1 = motor outputs allowed, 0 = gated off
//  last_src    out  1  requester of last granted request: 0 = wall, 1 = remote
//  fault       out  1  1 while in FAULT
//  fault_code  out  2  0 none, 1 ack/timeout, 2 obstruction, 3 limit-switch inconsistency
// BEHAVIOUR
//  - Reset: all outputs 0, state SYNC, counter 0, button history regs 0.
//  - States: SYNC, CLOSED, START_UP, OPENING, OPEN, START_DN, CLOSING, FAULT.
//  - SYNC (1 cycle): dn_max&!up_max -> CLOSED; up_max&!dn_max -> OPEN; else FAULT code 3.
//  - motor_en: registered, 1 in every state except SYNC and FAULT.
//  - Request = rising edge (btn & ~btn_q) of either button; sampled only in CLOSED/OPEN,
//    ignored (not queued) in all other states. Both edges same cycle: one grant, wall wins, last_src=0.
//  - Grant in cycle N: activate=1 in cycle N+1 only; last_src updated in N+1; state -> START_UP/START_DN.
//  - CLOSED + request -> START_UP. OPEN + request -> START_DN unless obstruct=1 (request dropped).
//  - START_UP: up_m=1 -> OPENING; counter reaches ACK_CYC without it -> FAULT code 1.
//  - START_DN: same with dn_m -> CLOSING; obstruct=1 -> FAULT code 2.
//  - OPENING: up_max=1 -> OPEN; counter reaches MOVE_TIMEOUT -> FAULT code 1.
//  - CLOSING: dn_max=1 -> CLOSED; obstruct=1 -> FAULT code 2 (priority over dn_max);
//    timeout -> FAULT code 1.
//  - OPEN: counter increments each cycle; held at 0 while obstruct=1;
//    counter == AUTO_CLOSE_CYC-1 -> auto grant (activate next cycle, last_src unchanged) -> START_DN.
//    User request and auto-close in same cycle: one activate, user request wins (last_src updated).
//  - Counter clears on every state change; saturates at 2^CNT_W-1, never wraps.
//  - up_max&dn_max both 1 in any state except FAULT -> FAULT code 3 (highest priority).
//  - FAULT: sticky, exits only via rst; activate=0, motor_en=0, fault=1, fault_code held.
//  - rst asserted mid-travel: immediate return to reset values next edge; SYNC then re-evaluates
//    switches (door mid-travel -> FAULT code 3).
// TESTING
//  1. rst 2 cycles, dn_max=1 -> CLOSED; wall_btn rise -> activate 1-cycle pulse, last_src=0; up_m=1
//     within 4 cycles -> OPENING; up_max=1 -> OPEN, fault=0.
//  2. OPEN, no requests, AUTO_CLOSE_CYC=20 -> activate pulse exactly 20 cycles after OPEN entry;
//     obstruct held 5 cycles in between -> pulse delayed to 20 cycles after obstruct falls.
//  3. wall_btn and remote_btn rise same cycle in CLOSED -> exactly one activate, last_src=0;
//     remote_btn rise while OPENING -> no activate.
//  4. CLOSING, obstruct=1 -> next cycle fault=1, fault_code=2, motor_en=0; further buttons ignored
//     until rst.
//  5. START_UP with up_m held 0 -> fault_code=1 after ACK_CYC=4 cycles; OPENING without up_max for
//     MOVE_TIMEOUT cycles -> fault_code=1.
//  6. up_max=dn_max=1 in OPEN -> fault_code=3; rst with up_max=dn_max=0 -> SYNC -> fault_code=3.

Source files
------------

// File: rtl/garage_door_supervisor.sv
// Supervisory controller for the garage door FSM. It arbitrates the wall and remote
// requests into single activate pulses, auto-closes an open door and latches faults.
module garage_door_supervisor #(
  parameter int CNT_W          = 16,
  parameter int ACK_CYC        = 4,
  parameter int MOVE_TIMEOUT   = 500,
  parameter int AUTO_CLOSE_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wall_btn,
  input  logic       remote_btn,
  input  logic       up_max,
  input  logic       dn_max,
  input  logic       obstruct,
  input  logic       up_m,
  input  logic       dn_m,
  output logic       activate,
  output logic       motor_en,
  output logic       last_src,
  output logic       fault,
  output logic [1:0] fault_code
);

  typedef enum logic [2:0] {
    SYNC, CLOSED, START_UP, OPENING, OPEN, START_DN, CLOSING, FAULT
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE, FC_TIMEOUT, FC_OBSTRUCT, FC_LIMIT
  } fcode_e;

  typedef struct packed {
    logic req;
    logic src;  // 0 = wall, 1 = remote
  } grant_t;

  // Each limit is compared in the last cycle of its window, so the window is exactly N cycles long.
  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_CYC - 1);
  localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] AUTO_LAST = CNT_W'(AUTO_CLOSE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wall_q, wall_d;
  logic             remote_q, remote_d;
  logic             activate_q, activate_d;
  logic             motor_en_q, motor_en_d;
  logic             last_src_q, last_src_d;
  logic             fault_q, fault_d;
  fcode_e           fault_code_q, fault_code_d;

  logic   wall_rise, remote_rise;
  grant_t user_req;

  always_comb begin
    wall_rise    = wall_btn & ~wall_q;
    remote_rise  = remote_btn & ~remote_q;
    user_req.req = wall_rise | remote_rise;
    user_req.src = ~wall_rise;  // wall wins a same-cycle tie

    state_d      = state_q;
    fault_code_d = fault_code_q;
    last_src_d   = last_src_q;
    activate_d   = 1'b0;
    wall_d       = wall_btn;
    remote_d     = remote_btn;

    unique case (state_q)
      SYNC: begin
        if (dn_max && !up_max) begin
          state_d = CLOSED;
        end else if (up_max && !dn_max) begin
          state_d = OPEN;
        end else begin
          state_d      = FAULT;
          fault_code_d = FC_LIMIT;
        end
      end
      CLOSED: begin
        if (user_req.req) begin
          state_d    = START_UP;
          activate_d = 1'b1;
          last_src_d = user_req.src;
        end
      end
      START_UP: begin
        if (up_m) begin
          state_d = OPENING;
        end else if (cnt_q >= ACK_LAST) begin
          state_d      = FAULT;
          fault_code_d = FC_TIMEOUT;
        end
      end
      OPENING: begin
        if (up_max) begin
          state_d = OPEN;
        end else if (cnt_q >= MOVE_LAST) begin
          state_d      = FAULT;
          fault_code_d = FC_TIMEOUT;
        end
      end
      OPEN: begin
        // Closing onto an obstruction is refused outright; the request is not remembered.
        if (!obstruct) begin
          if (user_req.req) begin
            state_d    = START_DN;
            activate_d = 1'b1;
            last_src_d = user_req.src;
          end else if (cnt_q >= AUTO_LAST) begin
            state_d    = START_DN;
            activate_d = 1'b1;
          end
        end
      end
      START_DN: begin
        if (obstruct) begin
          state_d      = FAULT;
          fault_code_d = FC_OBSTRUCT;
        end else if (dn_m) begin
          state_d = CLOSING;
        end else if (cnt_q >= ACK_LAST) begin
          state_d      = FAULT;
          fault_code_d = FC_TIMEOUT;
        end
      end
      CLOSING: begin
        if (obstruct) begin
          state_d      = FAULT;
          fault_code_d = FC_OBSTRUCT;
        end else if (dn_max) begin
          state_d = CLOSED;
        end else if (cnt_q >= MOVE_LAST) begin
          state_d      = FAULT;
          fault_code_d = FC_TIMEOUT;
        end
      end
      FAULT: ;
      default: begin
        state_d      = FAULT;
        fault_code_d = FC_LIMIT;
      end
    endcase

    // Both limit switches closed is physically impossible and overrides everything else.
    if (state_q != FAULT && up_max && dn_max) begin
      state_d      = FAULT;
      fault_code_d = FC_LIMIT;
      activate_d   = 1'b0;
      last_src_d   = last_src_q;
    end

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == OPEN && obstruct) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    motor_en_d = !(state_d inside {SYNC, FAULT});
    fault_d    = (state_d == FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SYNC;
      cnt_q        <= '0;
      wall_q       <= 1'b0;
      remote_q     <= 1'b0;
      activate_q   <= 1'b0;
      motor_en_q   <= 1'b0;
      last_src_q   <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= FC_NONE;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wall_q       <= wall_d;
      remote_q     <= remote_d;
      activate_q   <= activate_d;
      motor_en_q   <= motor_en_d;
      last_src_q   <= last_src_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

  assign activate   = activate_q;
  assign motor_en   = motor_en_q;
  assign last_src   = last_src_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;

endmodule

// File: tb/tb_garage_door_supervisor.sv
// Directed bench for garage_door_supervisor: a linear sequence of steps with hand-derived expectations.
module tb_garage_door_supervisor;

  logic       clk = 1'b0;
  logic       rst, wall_btn, remote_btn, up_max, dn_max, obstruct, up_m, dn_m;
  logic       activate, motor_en, last_src, fault;
  logic [1:0] fault_code;

  int checks = 0;
  int errors = 0;

  garage_door_supervisor #(
    .CNT_W(16), .ACK_CYC(4), .MOVE_TIMEOUT(40), .AUTO_CLOSE_CYC(20)
  ) dut (
    .clk(clk), .rst(rst), .wall_btn(wall_btn), .remote_btn(remote_btn),
    .up_max(up_max), .dn_max(dn_max), .obstruct(obstruct), .up_m(up_m), .dn_m(dn_m),
    .activate(activate), .motor_en(motor_en), .last_src(last_src),
    .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic upm, input logic dnm);
    rst = 1'b1; wall_btn = 0; remote_btn = 0; obstruct = 0; up_m = 0; dn_m = 0;
    up_max = upm; dn_max = dnm;
    tick(2);
    chk("rst_activate", activate, 0);
    chk("rst_motor_en", motor_en, 0);
    chk("rst_last_src", last_src, 0);
    chk("rst_fault", fault, 0);
    chk("rst_code", fault_code, 0);
    rst = 1'b0;
    tick(1);
  endtask

  initial begin
    #1;
    // 1: closed -> wall request -> opening -> open
    do_reset(0, 1);
    chk("t1_closed_motor_en", motor_en, 1);
    wall_btn = 1; tick(1);
    chk("t1_activate", activate, 1);
    chk("t1_last_src", last_src, 0);
    wall_btn = 0; up_m = 1; dn_max = 0; tick(1);
    chk("t1_pulse_one_cycle", activate, 0);
    tick(3);
    up_max = 1; up_m = 0; tick(1);
    chk("t1_open_fault", fault, 0);
    chk("t1_open_motor_en", motor_en, 1);
    // 2a: auto-close exactly 20 cycles after OPEN entry
    tick(19);
    chk("t2_auto_early", activate, 0);
    tick(1);
    chk("t2_auto_pulse", activate, 1);
    chk("t2_auto_src", last_src, 0);
    dn_m = 1; up_max = 0; tick(1);
    chk("t2_closing_no_pulse", activate, 0);
    tick(2);
    dn_m = 0; dn_max = 1; tick(1);
    chk("t2_closed_motor_en", motor_en, 1);
    // 3: simultaneous requests -> one grant, wall wins
    wall_btn = 1; remote_btn = 1; tick(1);
    chk("t3_tie_activate", activate, 1);
    chk("t3_tie_src", last_src, 0);
    wall_btn = 0; remote_btn = 0; up_m = 1; dn_max = 0; tick(1);
    chk("t3_tie_single", activate, 0);
    remote_btn = 1; tick(1);
    chk("t3_opening_ignored", activate, 0);
    tick(1);
    chk("t3_opening_ignored2", activate, 0);
    up_max = 1; up_m = 0; tick(1);
    chk("t3_not_queued_a", activate, 0);
    tick(1);
    chk("t3_not_queued_b", activate, 0);
    remote_btn = 0; tick(1);
    remote_btn = 1; tick(1);
    chk("t3_open_remote_act", activate, 1);
    chk("t3_open_remote_src", last_src, 1);
    remote_btn = 0; dn_m = 1; up_max = 0; tick(1);
    dn_m = 0; dn_max = 1; tick(1);
    chk("t3_back_closed_fault", fault, 0);
    // 2b: obstruction holds the auto-close counter; request under obstruction dropped
    remote_btn = 1; tick(1);
    chk("t2b_activate", activate, 1);
    chk("t2b_src", last_src, 1);
    remote_btn = 0; up_m = 1; dn_max = 0; tick(1);
    up_max = 1; up_m = 0; tick(1);
    tick(5);
    obstruct = 1; tick(1);
    wall_btn = 1; tick(1);
    chk("t2b_req_dropped", activate, 0);
    wall_btn = 0; tick(3);
    obstruct = 0;
    tick(19);
    chk("t2b_delayed_early", activate, 0);
    tick(1);
    chk("t2b_delayed_pulse", activate, 1);
    chk("t2b_src_kept", last_src, 1);
    // 4: obstruction while closing
    dn_m = 1; up_max = 0; tick(1);
    obstruct = 1; tick(1);
    chk("t4_fault", fault, 1);
    chk("t4_code", fault_code, 2);
    chk("t4_motor_en", motor_en, 0);
    obstruct = 0; dn_m = 0; dn_max = 1; wall_btn = 1; tick(1);
    chk("t4_btn_ignored", activate, 0);
    chk("t4_sticky", fault, 1);
    chk("t4_code_held", fault_code, 2);
    // 5a: no motor ack
    do_reset(0, 1);
    wall_btn = 1; tick(1);
    chk("t5a_activate", activate, 1);
    wall_btn = 0; tick(3);
    chk("t5a_before_limit", fault, 0);
    tick(1);
    chk("t5a_fault", fault, 1);
    chk("t5a_code", fault_code, 1);
    chk("t5a_motor_en", motor_en, 0);
    // 5b: ack in last allowed cycle, then travel timeout
    do_reset(0, 1);
    wall_btn = 1; tick(1);
    wall_btn = 0; tick(3);
    up_m = 1; dn_max = 0; tick(1);
    chk("t5b_late_ack_ok", fault, 0);
    chk("t5b_motor_en", motor_en, 1);
    tick(39);
    chk("t5b_before_timeout", fault, 0);
    tick(1);
    chk("t5b_timeout_fault", fault, 1);
    chk("t5b_timeout_code", fault_code, 1);
    // 6: limit switch inconsistency, and reset with door mid-travel
    do_reset(1, 0);
    chk("t6_open_motor_en", motor_en, 1);
    dn_max = 1; tick(1);
    chk("t6_both_fault", fault, 1);
    chk("t6_both_code", fault_code, 3);
    do_reset(0, 0);
    chk("t6_sync_fault", fault, 1);
    chk("t6_sync_code", fault_code, 3);
    chk("t6_sync_motor_en", motor_en, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
